// File: rtl/uart_rx_cfg_if.sv
// uart_rx_cfg_if
// Signal bundle between a serial-line source and the configurable UART
// receiver.
//   master : drives the serial line and the frame configuration, and
//            observes the received word and the status pulses
//   slave  : the receiver itself
// Signals:
//   RX_IN      serial line, idle high, already synchronous to UART_CLK
//   PRESCALE   UART_CLK cycles per bit (even, 8..32)
//   PAR_EN     parity bit present
//   PAR_TYP    0 = even parity, 1 = odd parity
//   STOP2      1 = two stop bits, 0 = one stop bit
//   P_DATA     last good word, LSB = first received data bit
//   data_valid one-cycle pulse, P_DATA updated in the same cycle
//   par_err    one-cycle pulse, parity mismatch
//   stp_err    one-cycle pulse, a stop bit was voted low
//   busy       high while a frame is being received
interface uart_rx_cfg_if #(
  parameter int DATA_WIDTH = 8,
  parameter int PRESCALE_W = 6
);
  logic                  RX_IN;
  logic [PRESCALE_W-1:0] PRESCALE;
  logic                  PAR_EN;
  logic                  PAR_TYP;
  logic                  STOP2;
  logic [DATA_WIDTH-1:0] P_DATA;
  logic                  data_valid;
  logic                  par_err;
  logic                  stp_err;
  logic                  busy;

  modport master (
    output RX_IN, PRESCALE, PAR_EN, PAR_TYP, STOP2,
    input  P_DATA, data_valid, par_err, stp_err, busy
  );

  modport slave (
    input  RX_IN, PRESCALE, PAR_EN, PAR_TYP, STOP2,
    output P_DATA, data_valid, par_err, stp_err, busy
  );
endinterface

// File: rtl/uart_rx_cfg.sv
// uart_rx_cfg
// Oversampling UART receiver with configurable data width, runtime prescale,
// optional even/odd parity and one or two stop bits. Every bit is decided by
// a 3-sample majority vote around the bit centre. A frame ends with either a
// data_valid pulse (P_DATA loaded) or an error pulse (par_err and/or stp_err).
// Ports:
//   UART_CLK  oversampling clock, sole clock of this block
//   RST       synchronous, active-high reset
//   bus       uart_rx_cfg_if slave modport (serial line, configuration,
//             received word and status pulses)
module uart_rx_cfg #(
  parameter int DATA_WIDTH = 8,
  parameter int PRESCALE_W = 6
) (
  input  logic         UART_CLK,
  input  logic         RST,
  uart_rx_cfg_if.slave bus
);

  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;

  state_t                state_reg, state_next;
  logic [PRESCALE_W-1:0] edge_cnt_reg, edge_cnt_next;
  // Counts every bit of the frame: 0 = start, 1..DATA_WIDTH = data, then
  // optional parity, then the stop bits.
  logic [3:0]            bit_cnt_reg, bit_cnt_next;
  logic [PRESCALE_W-1:0] prescale_reg, prescale_next;
  logic                  par_en_reg, par_en_next;
  logic                  par_typ_reg, par_typ_next;
  logic                  stop2_reg, stop2_next;
  logic                  samp_a_reg, samp_a_next;
  logic                  samp_b_reg, samp_b_next;
  logic [DATA_WIDTH-1:0] shift_reg, shift_next;
  logic [DATA_WIDTH-1:0] p_data_reg, p_data_next;
  logic                  par_flag_reg, par_flag_next;
  logic                  stp_flag_reg, stp_flag_next;
  logic                  dv_reg, dv_next;
  logic                  pe_reg, pe_next;
  logic                  se_reg, se_next;
  logic                  busy_reg, busy_next;

  logic [PRESCALE_W-1:0] half;
  logic                  at_samp_a, at_samp_b, at_vote, at_wrap;
  logic                  vote, exp_par, stop_bad;
  logic [3:0]            last_bit;

  assign half      = prescale_reg >> 1;
  assign at_samp_a = (edge_cnt_reg == half - PRESCALE_W'(1));
  assign at_samp_b = (edge_cnt_reg == half);
  assign at_vote   = (edge_cnt_reg == half + PRESCALE_W'(1));
  assign at_wrap   = (edge_cnt_reg == prescale_reg - PRESCALE_W'(1));

  // Two registered samples plus the live line form the majority vote.
  assign vote = (samp_a_reg & samp_b_reg) | (samp_a_reg & bus.RX_IN) |
                (samp_b_reg & bus.RX_IN);

  assign exp_par  = par_typ_reg ? ~^shift_reg : ^shift_reg;
  assign stop_bad = stp_flag_reg | ~vote;
  // Index of the final stop bit; the frame closes at its vote.
  assign last_bit = 4'(DATA_WIDTH) + {3'b000, par_en_reg} +
                    (stop2_reg ? 4'd2 : 4'd1);

  always_comb begin
    state_next    = state_reg;
    edge_cnt_next = edge_cnt_reg;
    bit_cnt_next  = bit_cnt_reg;
    prescale_next = prescale_reg;
    par_en_next   = par_en_reg;
    par_typ_next  = par_typ_reg;
    stop2_next    = stop2_reg;
    samp_a_next   = samp_a_reg;
    samp_b_next   = samp_b_reg;
    shift_next    = shift_reg;
    p_data_next   = p_data_reg;
    par_flag_next = par_flag_reg;
    stp_flag_next = stp_flag_reg;
    dv_next       = 1'b0;
    pe_next       = 1'b0;
    se_next       = 1'b0;
    busy_next     = busy_reg;

    if (state_reg != IDLE) begin
      if (at_wrap) begin
        edge_cnt_next = '0;
        bit_cnt_next  = bit_cnt_reg + 4'd1;
      end else begin
        edge_cnt_next = edge_cnt_reg + PRESCALE_W'(1);
      end
      if (at_samp_a) samp_a_next = bus.RX_IN;
      if (at_samp_b) samp_b_next = bus.RX_IN;
    end

    case (state_reg)
      IDLE: begin
        if (!bus.RX_IN) begin
          // This cycle is tick 0 of the start bit, so the count resumes at 1.
          state_next    = START;
          edge_cnt_next = PRESCALE_W'(1);
          bit_cnt_next  = '0;
          prescale_next = bus.PRESCALE;
          par_en_next   = bus.PAR_EN;
          par_typ_next  = bus.PAR_TYP;
          stop2_next    = bus.STOP2;
          par_flag_next = 1'b0;
          stp_flag_next = 1'b0;
          busy_next     = 1'b1;
        end
      end
      START: begin
        if (at_vote && vote) begin
          state_next    = IDLE;
          edge_cnt_next = '0;
          bit_cnt_next  = '0;
          busy_next     = 1'b0;
        end else if (at_wrap) begin
          state_next = DATA;
        end
      end
      DATA: begin
        // Right shift: the first bit received ends up in the LSB.
        if (at_vote) shift_next = {vote, shift_reg[DATA_WIDTH-1:1]};
        if (at_wrap && bit_cnt_reg == 4'(DATA_WIDTH))
          state_next = par_en_reg ? PARITY : STOP;
      end
      PARITY: begin
        if (at_vote) par_flag_next = (vote != exp_par);
        if (at_wrap) state_next = STOP;
      end
      STOP: begin
        if (at_vote) begin
          stp_flag_next = stop_bad;
          if (bit_cnt_reg == last_bit) begin
            if (par_flag_reg || stop_bad) begin
              pe_next = par_flag_reg;
              se_next = stop_bad;
            end else begin
              dv_next     = 1'b1;
              p_data_next = shift_reg;
            end
            state_next    = IDLE;
            edge_cnt_next = '0;
            bit_cnt_next  = '0;
            busy_next     = 1'b0;
          end
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge UART_CLK) begin
    if (RST) begin
      state_reg    <= IDLE;
      edge_cnt_reg <= '0;
      bit_cnt_reg  <= '0;
      prescale_reg <= '0;
      par_en_reg   <= 1'b0;
      par_typ_reg  <= 1'b0;
      stop2_reg    <= 1'b0;
      samp_a_reg   <= 1'b1;
      samp_b_reg   <= 1'b1;
      shift_reg    <= '0;
      p_data_reg   <= '0;
      par_flag_reg <= 1'b0;
      stp_flag_reg <= 1'b0;
      dv_reg       <= 1'b0;
      pe_reg       <= 1'b0;
      se_reg       <= 1'b0;
      busy_reg     <= 1'b0;
    end else begin
      state_reg    <= state_next;
      edge_cnt_reg <= edge_cnt_next;
      bit_cnt_reg  <= bit_cnt_next;
      prescale_reg <= prescale_next;
      par_en_reg   <= par_en_next;
      par_typ_reg  <= par_typ_next;
      stop2_reg    <= stop2_next;
      samp_a_reg   <= samp_a_next;
      samp_b_reg   <= samp_b_next;
      shift_reg    <= shift_next;
      p_data_reg   <= p_data_next;
      par_flag_reg <= par_flag_next;
      stp_flag_reg <= stp_flag_next;
      dv_reg       <= dv_next;
      pe_reg       <= pe_next;
      se_reg       <= se_next;
      busy_reg     <= busy_next;
    end
  end

  assign bus.P_DATA     = p_data_reg;
  assign bus.data_valid = dv_reg;
  assign bus.par_err    = pe_reg;
  assign bus.stp_err    = se_reg;
  assign bus.busy       = busy_reg;

endmodule

// File: tb/tb_uart_rx_cfg.sv
// tb_uart_rx_cfg
// Drives one serial line into two receivers (8-bit and 5-bit data width).
// Each receiver has a frame-level reference model that works from the
// recorded line history and absolute bit/tick arithmetic.
module tb_uart_rx_cfg;
  localparam int PW = 6;

  logic          clk = 1'b0;
  logic          rst;
  logic          rx;
  logic [PW-1:0] prescale;
  logic          par_en, par_typ, stop2;

  int cyc   = 0;
  int total = 0;
  int bad   = 0;

  // Last observed event cycles and word per receiver.
  int dv_cyc [2];
  int pe_cyc [2];
  int se_cyc [2];
  int rise_cyc [2];
  int fall_cyc [2];
  int last_data [2];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s cyc=%0d got=%0h want=%0h", name, cyc, act, exp);
    end
  endtask

  for (genvar gi = 0; gi < 2; gi++) begin : g_inst
    localparam int DW = (gi == 0) ? 8 : 5;

    uart_rx_cfg_if #(.DATA_WIDTH(DW), .PRESCALE_W(PW)) bus ();
    assign bus.RX_IN    = rx;
    assign bus.PRESCALE = prescale;
    assign bus.PAR_EN   = par_en;
    assign bus.PAR_TYP  = par_typ;
    assign bus.STOP2    = stop2;

    uart_rx_cfg #(.DATA_WIDTH(DW), .PRESCALE_W(PW)) dut (
      .UART_CLK (clk),
      .RST      (rst),
      .bus      (bus)
    );

    bit            hist [0:511];
    bit            in_frame, mpe, mpt, ms2, pflag, sflag, v, prev_busy;
    int            t0, mp, nb, off, k, e, c_end;
    logic [DW-1:0] sh, e_data;
    bit            e_dv, e_pe, e_se, e_busy;

    initial begin
      in_frame = 0; prev_busy = 0; e_data = '0; e_busy = 0;
      e_dv = 0; e_pe = 0; e_se = 0; sh = '0; pflag = 0; sflag = 0;
      t0 = 0; mp = 16; mpe = 0; mpt = 0; ms2 = 0;
      dv_cyc[gi] = -1; pe_cyc[gi] = -1; se_cyc[gi] = -1;
      rise_cyc[gi] = -1; fall_cyc[gi] = -1; last_data[gi] = 0;
      forever begin
        @(posedge clk);
        c_end = cyc;
        e_dv = 0; e_pe = 0; e_se = 0;
        if (rst) begin
          in_frame = 0; e_busy = 0; e_data = '0;
        end else if (!in_frame) begin
          if (!rx) begin
            in_frame = 1; t0 = c_end; e_busy = 1;
            mp = int'(prescale); mpe = par_en; mpt = par_typ; ms2 = stop2;
            pflag = 0; sflag = 0; hist[0] = 0;
          end
        end else begin
          off = c_end - t0;
          hist[off] = rx;
          k = off / mp;
          e = off % mp;
          nb = 1 + DW + int'(mpe) + (ms2 ? 2 : 1);
          if (e == mp / 2 + 1) begin
            v = (int'(hist[off-2]) + int'(hist[off-1]) + int'(hist[off])) >= 2;
            if (k == 0) begin
              if (v) begin in_frame = 0; e_busy = 0; end
            end else if (k <= DW) begin
              sh[k-1] = v;
            end else if (mpe && k == DW + 1) begin
              pflag = (v != (mpt ? ~^sh : ^sh));
            end else if (!v) begin
              sflag = 1;
            end
            if (k == nb - 1) begin
              in_frame = 0; e_busy = 0;
              if (pflag || sflag) begin
                e_pe = pflag; e_se = sflag;
              end else begin
                e_dv = 1; e_data = sh;
              end
            end
          end
        end
        #2;
        chk($sformatf("dv%0d", gi),   int'(bus.data_valid), int'(e_dv));
        chk($sformatf("pe%0d", gi),   int'(bus.par_err),    int'(e_pe));
        chk($sformatf("se%0d", gi),   int'(bus.stp_err),    int'(e_se));
        chk($sformatf("busy%0d", gi), int'(bus.busy),       int'(e_busy));
        chk($sformatf("data%0d", gi), int'(bus.P_DATA),     int'(e_data));
        if (bus.data_valid) dv_cyc[gi] = cyc;
        if (bus.par_err)    pe_cyc[gi] = cyc;
        if (bus.stp_err)    se_cyc[gi] = cyc;
        if (bus.busy && !prev_busy) rise_cyc[gi] = cyc;
        if (!bus.busy && prev_busy) fall_cyc[gi] = cyc;
        prev_busy     = bus.busy;
        last_data[gi] = int'(bus.P_DATA);
      end
    end
  end

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk); #1;
      rx = 1'b1;
    end
  endtask

  task automatic clear_events();
    for (int i = 0; i < 2; i++) begin
      dv_cyc[i] = -1; pe_cyc[i] = -1; se_cyc[i] = -1;
      rise_cyc[i] = -1; fall_cyc[i] = -1;
    end
  endtask

  // Drives one frame; s returns the cycle of its first start-bit tick.
  // glitch_bit flips tick P/2 of that bit; abort_at pulses RST at that tick.
  task automatic send_frame(input int dw, input int p, input bit pe,
                            input bit pt, input bit s2, input int data,
                            input bit flip_par, input bit stop_low,
                            input int glitch_bit, input int abort_at,
                            input bit chaos, output int s);
    bit bits [16];
    int nbits, d, idx;
    d = data & ((1 << dw) - 1);
    nbits = 0;
    bits[nbits++] = 1'b0;
    for (int i = 0; i < dw; i++) bits[nbits++] = d[i];
    if (pe) bits[nbits++] = (pt ? ~(^d) : ^d) ^ flip_par;
    for (int i = 0; i < (s2 ? 2 : 1); i++) bits[nbits++] = ~stop_low;
    idx = 0;
    s = 0;
    for (int b = 0; b < nbits; b++) begin
      for (int t = 0; t < p; t++) begin
        @(posedge clk); #1;
        if (idx == abort_at) begin
          rst = 1'b1; rx = 1'b1;
          @(posedge clk); #1;
          rst = 1'b0;
          return;
        end
        rx = (b == glitch_bit && t == p / 2) ? ~bits[b] : bits[b];
        if (idx == 0) begin
          prescale = PW'(p); par_en = pe; par_typ = pt; stop2 = s2;
          s = cyc;
        end else if (idx == 1 && chaos) begin
          prescale = PW'(2 * $urandom_range(4, 16));
          par_en = 1'($urandom); par_typ = 1'($urandom); stop2 = 1'($urandom);
        end
        idx++;
      end
    end
  endtask

  initial begin
    int s, d, dw, p, gb, ab;
    rst = 1'b1; rx = 1'b1; prescale = PW'(16);
    par_en = 1'b0; par_typ = 1'b0; stop2 = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    idle(5);
    chk("reset_pdata", last_data[0], 0);
    chk("reset_no_busy", rise_cyc[0], -1);

    // 0xA5, P=16, no parity, one stop
    clear_events();
    send_frame(8, 16, 0, 0, 0, 'hA5, 0, 0, -1, -1, 0, s);
    chk("a5_dv_cycle", dv_cyc[0] - s, 154);
    chk("a5_data", last_data[0], 'hA5);
    chk("a5_no_err", pe_cyc[0] + se_cyc[0], -2);
    idle(10);

    // 0x3C, even parity, two stops, wrong parity bit: word holds 0xA5
    clear_events();
    send_frame(8, 16, 1, 0, 1, 'h3C, 1, 0, -1, -1, 0, s);
    chk("badpar_pe_cycle", pe_cyc[0] - s, 186);
    chk("badpar_no_dv", dv_cyc[0], -1);
    chk("badpar_hold", last_data[0], 'hA5);
    idle(10);

    // Same frame with correct parity bit 0
    clear_events();
    send_frame(8, 16, 1, 0, 1, 'h3C, 0, 0, -1, -1, 0, s);
    chk("3c_dv_cycle", dv_cyc[0] - s, 186);
    chk("3c_data", last_data[0], 'h3C);
    idle(10);

    // Single-sample glitch at tick P/2 of data bit 3
    send_frame(8, 16, 0, 0, 0, 'h5A, 0, 0, 4, -1, 0, s);
    chk("glitch_bit_data", last_data[0], 'h5A);

    // 5-bit receiver: odd parity, P=8, 0x13, then the same with stop low
    idle(450);
    clear_events();
    send_frame(5, 8, 1, 1, 0, 'h13, 0, 0, -1, -1, 0, s);
    chk("w5_dv_cycle", dv_cyc[1] - s, 62);
    chk("w5_data", last_data[1], 'h13);
    clear_events();
    send_frame(5, 8, 1, 1, 0, 'h13, 0, 1, -1, -1, 0, s);
    idle(20);
    chk("w5_se_cycle", se_cyc[1] - s, 62);
    chk("w5_no_dv", dv_cyc[1], -1);
    chk("w5_restart", rise_cyc[1] - s, 63);
    chk("w5_hold", last_data[1], 'h13);

    // Start glitch: line low for 3 cycles only
    idle(450);
    clear_events();
    @(posedge clk); #1;
    rx = 1'b0; prescale = PW'(16); par_en = 1'b0; par_typ = 1'b0; stop2 = 1'b0;
    s = cyc;
    repeat (2) begin @(posedge clk); #1; rx = 1'b0; end
    idle(30);
    chk("glitch_rise", rise_cyc[0] - s, 1);
    chk("glitch_fall", fall_cyc[0] - s, 10);
    chk("glitch_fall_w5", fall_cyc[1] - s, 10);
    chk("glitch_no_pulse", dv_cyc[0] + pe_cyc[0] + se_cyc[0], -3);

    // Back-to-back 0x55, 0xAA at P=32
    idle(450);
    clear_events();
    send_frame(8, 32, 0, 0, 0, 'h55, 0, 0, -1, -1, 0, s);
    chk("b2b1_dv_cycle", dv_cyc[0] - s, 306);
    chk("b2b1_data", last_data[0], 'h55);
    d = dv_cyc[0];
    send_frame(8, 32, 0, 0, 0, 'hAA, 0, 0, -1, -1, 0, s);
    chk("b2b_spacing", dv_cyc[0] - d, 320);
    chk("b2b2_data", last_data[0], 'hAA);

    // Reset at tick 80 of a frame, then a clean 0x81
    idle(450);
    clear_events();
    send_frame(8, 16, 0, 0, 0, 'h3C, 0, 0, -1, 80, 0, s);
    idle(20);
    chk("rst_busy_fall", fall_cyc[0] - s, 81);
    chk("rst_pdata", last_data[0], 0);
    chk("rst_no_pulse", dv_cyc[0] + pe_cyc[0] + se_cyc[0], -3);
    clear_events();
    send_frame(8, 16, 0, 0, 0, 'h81, 0, 0, -1, -1, 0, s);
    chk("81_dv_cycle", dv_cyc[0] - s, 154);
    chk("81_data", last_data[0], 'h81);

    // Randomized frames
    idle(450);
    for (int i = 0; i < 40; i++) begin
      dw = ($urandom_range(0, 1) == 0) ? 8 : 5;
      p  = 2 * $urandom_range(4, 16);
      gb = ($urandom_range(0, 3) == 0) ? $urandom_range(0, 1 + dw) : -1;
      ab = ($urandom_range(0, 9) == 0) ? $urandom_range(10, 50) : -1;
      send_frame(dw, p, 1'($urandom), 1'($urandom), 1'($urandom),
                 int'($urandom_range(0, 511)),
                 $urandom_range(0, 5) == 0, $urandom_range(0, 7) == 0,
                 gb, ab, 1'b1, s);
      idle($urandom_range(0, 20));
    end
    idle(450);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #3000000;
    bad++;
    $display("FAIL watchdog cyc=%0d got=running want=finished", cyc);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/uart_rx_cfg.md
# uart_rx_cfg

Parametrised, oversampling UART receiver for the UART_CLK domain of the low-power processing system. It generalises the fixed 8-bit receiver to configurable data width, runtime prescale, parity mode (none/even/odd) and 1 or 2 stop bits. Each bit is recovered by 3-sample majority vote. Each frame yields either a one-cycle data-valid pulse with the parallel word, or a one-cycle error pulse. It feeds the data synchroniser toward the REF_CLK-domain system controller.

## Interface
- DATA_WIDTH, 8, data bits per frame; legal 5..9
- PRESCALE_W, 6, width of PRESCALE input
- UART_CLK  in  1  receiver clock (oversampling clock); sole clock
- RST  in  1  synchronous, active-high reset
- RX_IN  in  1  serial line, idle high, already synchronised to UART_CLK upstream
- PRESCALE  in  PRESCALE_W  UART_CLK cycles per bit; legal: even values 8..32
- PAR_EN  in  1  1 = parity bit present
- PAR_TYP  in  1  0 = even, 1 = odd
- STOP2  in  1  1 = two stop bits, 0 = one
- P_DATA  out  DATA_WIDTH  last good word, LSB = first received bit
- data_valid  out  1  one-cycle pulse, P_DATA updated in same cycle
- par_err  out  1  one-cycle pulse, parity mismatch
- stp_err  out  1  one-cycle pulse, a stop bit sampled low
- busy  out  1  high while a frame is in progress

## Operation
- Reset values: P_DATA = 0, data_valid = par_err = stp_err = busy = 0, state IDLE, edge/bit counters 0.
- FSM states: IDLE, START, DATA, PARITY, STOP.
- IDLE: when RX_IN == 0, this cycle is tick 0 of the start bit. PRESCALE, PAR_EN, PAR_TYP and STOP2 are latched, then state goes to START. Input changes mid-frame are ignored.
- Edge counter runs 0..P-1 per bit (P = latched PRESCALE), then wraps with the bit counter incrementing.
- Sampling: RX_IN is registered at edge counts P/2-1 and P/2. The vote is the majority of those two samples plus live RX_IN at P/2+1.
- START: vote == 1 means glitch. Return to IDLE next cycle with no pulses. Vote == 0 means continue to DATA at the bit boundary.
- DATA: DATA_WIDTH votes shifted in LSB-first, then go to PARITY if PAR_EN, else STOP.
- PARITY: the expected bit is ^data for even and ~^data for odd. A mismatch sets the internal parity flag.
- STOP: 1 or 2 stop bits. Any stop vote of 0 sets the internal stop flag.
- End of frame: this happens at the vote of the last stop bit, without waiting for the end of that bit, and the FSM returns to IDLE next cycle.
  - No flags set: data_valid pulses and P_DATA loads.
  - Any flag set: par_err and/or stp_err pulse (both may assert together), data_valid stays 0 and P_DATA holds.
- A stop bit held low (break) re-triggers start detection from IDLE. This is the defined behaviour.
- RST high mid-frame: at the next edge, all outputs and state return to reset values. The partial frame is discarded and no pulse is emitted.
- PRESCALE outside even 8..32 is out of contract.

## Timing
- Cycle 0 is the IDLE cycle that first sees RX_IN == 0.
- Bit k (start = 0) is voted at cycle k·P + P/2 + 1. Registered results are visible at k·P + P/2 + 2.
- Frame bits N = 1 + DATA_WIDTH + PAR_EN + (STOP2 ? 2 : 1).
- Output pulse cycle = (N-1)·P + P/2 + 2.
  - DATA_WIDTH = 8, P = 16, no parity, 1 stop: cycle 154.
  - DATA_WIDTH = 8, P = 16, parity, 2 stops: cycle 186.
- busy rises at cycle 1. It is low in the output-pulse cycle and after it. A start glitch drops busy at cycle P/2 + 2.
- Back-to-back frames: the next start edge is accepted from the cycle after the output pulse, with no idle gap required.
- All outputs are registered. Pulses are exactly one cycle wide.

## Test plan
- P = 16, DATA_WIDTH = 8, no parity, 1 stop, frame 0xA5 -> data_valid at cycle 154, P_DATA = 0xA5, no errors.
- Even parity, 2 stops, 0x3C with parity bit 0 -> data_valid at cycle 186. The same frame with parity bit 1 -> par_err pulse, data_valid = 0, P_DATA holds 0xA5.
- Odd parity, DATA_WIDTH = 5, P = 8, data 0x13, parity 0 -> data_valid with P_DATA = 0x13. Next frame with stop bit 0 -> stp_err, then a new start detected in IDLE.
- RX_IN low for 3 cycles only, then high -> busy high for cycles 1..9, FSM back to IDLE, no pulses. A single-sample glitch inside a data bit at tick P/2 -> majority vote gives the correct bit.
- Two back-to-back frames 0x55, 0xAA at P = 32 with no idle gap -> two data_valid pulses 320 cycles apart, correct data.
- RST asserted at cycle 80 of a frame -> all outputs 0 next cycle, no pulse. The following clean frame 0x81 is received correctly.
